// File: rtl/timer_ctrl_master.sv
// Avalon-MM master for the 16-bit interval timer: programs the period, runs the timer
// continuously, clears each timeout, counts ticks and performs on-demand snapshot reads.
module timer_ctrl_master (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] cfg_period,
  input  logic        cfg_start,
  input  logic        cfg_stop,
  input  logic        snap_req,
  output logic [2:0]  m_address,
  output logic        m_chipselect,
  output logic        m_write_n,
  output logic [15:0] m_writedata,
  input  logic [15:0] m_readdata,
  input  logic        irq_in,
  output logic        busy,
  output logic        running,
  output logic [15:0] tick_count,
  output logic [31:0] snap_value,
  output logic        snap_valid
);

  // Bus handshake: a write is one cycle with m_chipselect=1, m_write_n=0; a read is one
  // cycle with m_chipselect=1, m_write_n=1 followed by one idle wait cycle, and
  // m_readdata is taken at the end of that wait cycle.
  typedef enum logic [3:0] {
    IDLE, WR_PL, WR_PH, WR_CTL, RUN, CLR_ST, WR_SNAP,
    RD_SL, RD_SL_W, RD_SH, RD_SH_W, WR_STOP
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] period_q, period_d;
  logic        stop_pend_q, stop_pend_d;
  logic        snap_pend_q, snap_pend_d;
  logic        snap_idle_q, snap_idle_d;
  logic        running_q, running_d;
  logic [15:0] tick_count_q, tick_count_d;
  logic [15:0] snap_lo_q, snap_lo_d;
  logic [31:0] snap_value_q, snap_value_d;
  logic        snap_valid_q, snap_valid_d;
  logic        cs_q, cs_d;
  logic        write_n_q, write_n_d;
  logic [2:0]  address_q, address_d;
  logic [15:0] writedata_q, writedata_d;
  logic        stop_any, snap_any;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      period_q     <= '0;
      stop_pend_q  <= 1'b0;
      snap_pend_q  <= 1'b0;
      snap_idle_q  <= 1'b0;
      running_q    <= 1'b0;
      tick_count_q <= '0;
      snap_lo_q    <= '0;
      snap_value_q <= '0;
      snap_valid_q <= 1'b0;
      cs_q         <= 1'b0;
      write_n_q    <= 1'b1;
      address_q    <= '0;
      writedata_q  <= '0;
    end else begin
      state_q      <= state_d;
      period_q     <= period_d;
      stop_pend_q  <= stop_pend_d;
      snap_pend_q  <= snap_pend_d;
      snap_idle_q  <= snap_idle_d;
      running_q    <= running_d;
      tick_count_q <= tick_count_d;
      snap_lo_q    <= snap_lo_d;
      snap_value_q <= snap_value_d;
      snap_valid_q <= snap_valid_d;
      cs_q         <= cs_d;
      write_n_q    <= write_n_d;
      address_q    <= address_d;
      writedata_q  <= writedata_d;
    end
  end

  always_comb begin
    stop_any     = stop_pend_q | cfg_stop;
    snap_any     = snap_pend_q | snap_req;
    state_d      = state_q;
    period_d     = period_q;
    stop_pend_d  = stop_any;
    snap_pend_d  = snap_any;
    snap_idle_d  = snap_idle_q;
    running_d    = running_q;
    tick_count_d = tick_count_q;
    snap_lo_d    = snap_lo_q;
    snap_value_d = snap_value_q;
    snap_valid_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        // A stop with nothing running has nothing to write.
        stop_pend_d = 1'b0;
        if (cfg_start) begin
          period_d = cfg_period;
          state_d  = WR_PL;
        end else if (snap_any) begin
          snap_pend_d = 1'b0;
          snap_idle_d = 1'b1;
          state_d     = WR_SNAP;
        end
      end
      WR_PL:  state_d = WR_PH;
      WR_PH:  state_d = WR_CTL;
      WR_CTL: begin
        running_d = 1'b1;
        state_d   = RUN;
      end
      RUN: begin
        if (stop_any) begin
          stop_pend_d = 1'b0;
          state_d     = WR_STOP;
        end else if (cfg_start) begin
          period_d = cfg_period;
          state_d  = WR_PL;
        end else if (irq_in) begin
          state_d = CLR_ST;
        end else if (snap_any) begin
          snap_pend_d = 1'b0;
          snap_idle_d = 1'b0;
          state_d     = WR_SNAP;
        end
      end
      CLR_ST: begin
        tick_count_d = tick_count_q + 16'd1;
        state_d      = RUN;
      end
      WR_SNAP: state_d = RD_SL;
      RD_SL:   state_d = RD_SL_W;
      RD_SL_W: begin
        snap_lo_d = m_readdata;
        state_d   = RD_SH;
      end
      RD_SH:   state_d = RD_SH_W;
      RD_SH_W: begin
        snap_value_d = {m_readdata, snap_lo_q};
        snap_valid_d = 1'b1;
        state_d      = snap_idle_q ? IDLE : RUN;
      end
      WR_STOP: begin
        running_d = 1'b0;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Bus outputs are decoded from the next state so they are registered yet aligned
    // with the state that owns the bus cycle.
    cs_d        = 1'b0;
    write_n_d   = 1'b1;
    address_d   = 3'd0;
    writedata_d = 16'h0000;
    unique case (state_d)
      WR_PL:   begin cs_d = 1'b1; write_n_d = 1'b0; address_d = 3'd2; writedata_d = period_d[15:0];  end
      WR_PH:   begin cs_d = 1'b1; write_n_d = 1'b0; address_d = 3'd3; writedata_d = period_d[31:16]; end
      WR_CTL:  begin cs_d = 1'b1; write_n_d = 1'b0; address_d = 3'd1; writedata_d = 16'h0007;        end
      CLR_ST:  begin cs_d = 1'b1; write_n_d = 1'b0; address_d = 3'd0; writedata_d = 16'h0000;        end
      WR_SNAP: begin cs_d = 1'b1; write_n_d = 1'b0; address_d = 3'd4; writedata_d = 16'h0000;        end
      RD_SL:   begin cs_d = 1'b1; address_d = 3'd4; end
      RD_SH:   begin cs_d = 1'b1; address_d = 3'd5; end
      WR_STOP: begin cs_d = 1'b1; write_n_d = 1'b0; address_d = 3'd1; writedata_d = 16'h0008;        end
      default: begin cs_d = 1'b0; end
    endcase
  end

  assign m_chipselect = cs_q;
  assign m_write_n    = write_n_q;
  assign m_address    = address_q;
  assign m_writedata  = writedata_q;
  assign busy         = (state_q != IDLE) && (state_q != RUN);
  assign running      = running_q;
  assign tick_count   = tick_count_q;
  assign snap_value   = snap_value_q;
  assign snap_valid   = snap_valid_q;

endmodule

// File: tb/tb_timer_ctrl_master.sv
// Bench for timer_ctrl_master: a behavioural interval-timer slave, a bus-transaction
// scoreboard fed from the stimulus, and directed timing checks.
module tb_timer_ctrl_master;

  logic        clk;
  logic        reset_n;
  logic [31:0] cfg_period;
  logic        cfg_start, cfg_stop, snap_req;
  logic [2:0]  m_address;
  logic        m_chipselect, m_write_n;
  logic [15:0] m_writedata, m_readdata;
  logic        irq_in;
  logic        busy, running;
  logic [15:0] tick_count;
  logic [31:0] snap_value;
  logic        snap_valid;

  timer_ctrl_master dut (
    .clk(clk), .reset_n(reset_n), .cfg_period(cfg_period), .cfg_start(cfg_start),
    .cfg_stop(cfg_stop), .snap_req(snap_req), .m_address(m_address),
    .m_chipselect(m_chipselect), .m_write_n(m_write_n), .m_writedata(m_writedata),
    .m_readdata(m_readdata), .irq_in(irq_in), .busy(busy), .running(running),
    .tick_count(tick_count), .snap_value(snap_value), .snap_valid(snap_valid)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- timer slave model ----------------
  logic [15:0] t_pl, t_ph, t_snl, t_snh, rdata_q;
  logic [31:0] t_cnt;
  logic        t_run, t_ito, t_to;
  logic [15:0] fix_lo, fix_hi;

  assign irq_in     = t_to & t_ito;
  assign m_readdata = rdata_q;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      t_pl <= '0; t_ph <= '0; t_snl <= '0; t_snh <= '0; rdata_q <= '0;
      t_cnt <= '0; t_run <= 1'b0; t_ito <= 1'b0; t_to <= 1'b0;
    end else begin
      if (t_run) t_cnt <= (t_cnt == 32'd0) ? {t_ph, t_pl} : t_cnt - 32'd1;
      // the status clear wins over a timeout in the same cycle
      if (m_chipselect && !m_write_n && m_address == 3'd0) t_to <= 1'b0;
      else if (t_run && t_cnt == 32'd0) t_to <= 1'b1;
      if (m_chipselect && !m_write_n) begin
        case (m_address)
          3'd1: begin
            t_ito <= m_writedata[0];
            if (m_writedata[3]) t_run <= 1'b0;
            else if (m_writedata[2]) begin
              t_run <= 1'b1;
              t_cnt <= {t_ph, t_pl};
            end
          end
          3'd2: t_pl <= m_writedata;
          3'd3: t_ph <= m_writedata;
          3'd4: begin t_snl <= fix_lo; t_snh <= fix_hi; end
          default: ;
        endcase
      end
      // garbage outside the read-data slot exposes late or early capture
      if (m_chipselect && m_write_n)
        rdata_q <= (m_address == 3'd4) ? t_snl : (m_address == 3'd5) ? t_snh : 16'hDEAD;
      else
        rdata_q <= 16'($urandom);
    end
  end

  // ---------------- scoreboard ----------------
  int          n_checks = 0;
  int          n_pass = 0;
  logic [19:0] exp_q[$];      // {is_write, address, writedata}
  logic [31:0] snap_exp_q[$];
  logic [15:0] exp_tick = 16'h0;
  int          n_clr_seen = 0;
  logic        clr_track = 1'b1;
  logic        irq_prev = 1'b0;
  logic        prev_rd = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  always @(negedge clk) begin
    logic [19:0] obs;
    if (!reset_n) begin
      prev_rd  = 1'b0;
      irq_prev = 1'b0;
    end else begin
      if (prev_rd) check("rd_wait_cycle", 32'(m_chipselect), 32'd0);
      prev_rd = m_chipselect && m_write_n;
      if (m_chipselect) begin
        obs = {!m_write_n, m_address, m_write_n ? 16'h0000 : m_writedata};
        if (exp_q.size() == 0) check("bus_extra", 32'(obs), 32'hFFFFF);
        else check("bus_op", 32'(obs), 32'(exp_q.pop_front()));
        if (!m_write_n && m_address == 3'd0) n_clr_seen++;
      end
      if (irq_in && !irq_prev && clr_track) begin
        exp_q.push_back({1'b1, 3'd0, 16'h0000});
        exp_tick = exp_tick + 16'd1;
      end
      irq_prev = irq_in;
      if (snap_valid) begin
        if (snap_exp_q.size() == 0) check("snap_extra", 32'd1, 32'd0);
        else check("snap_value", snap_value, snap_exp_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic start_timer(input logic [31:0] per, input logic was_running);
    cfg_period = per;
    cfg_start  = 1'b1;
    exp_q.push_back({1'b1, 3'd2, per[15:0]});
    exp_q.push_back({1'b1, 3'd3, per[31:16]});
    exp_q.push_back({1'b1, 3'd1, 16'h0007});
    @(posedge clk); #1;
    cfg_start  = 1'b0;
    cfg_period = $urandom;
    @(negedge clk);
    check("start_wr_pl", {m_chipselect, m_write_n, m_address}, {1'b1, 1'b0, 3'd2});
    @(negedge clk);
    @(negedge clk);
    check("start_running_pre", 32'(running), 32'(was_running));
    @(negedge clk);
    check("start_running", 32'(running), 32'd1);
    check("start_busy", 32'(busy), 32'd0);
  endtask

  task automatic push_snap(input logic [15:0] lo, input logic [15:0] hi);
    fix_lo = lo;
    fix_hi = hi;
    exp_q.push_back({1'b1, 3'd4, 16'h0000});
    exp_q.push_back({1'b0, 3'd4, 16'h0000});
    exp_q.push_back({1'b0, 3'd5, 16'h0000});
    snap_exp_q.push_back({hi, lo});
  endtask

  task automatic wait_clr(input int n, input string tag);
    int k = 0;
    while (n_clr_seen < n && k < 200) begin
      @(negedge clk); #1;
      k++;
    end
    check(tag, 32'(n_clr_seen >= n), 32'd1);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int k;
    int base;
    logic [15:0] lo, hi;
    reset_n = 1'b0; cfg_period = '0; cfg_start = 1'b0; cfg_stop = 1'b0; snap_req = 1'b0;
    fix_lo = '0; fix_hi = '0;
    repeat (3) @(negedge clk);
    check("rst_bus", {m_chipselect, m_write_n, m_address, m_writedata}, {1'b0, 1'b1, 3'd0, 16'h0});
    check("rst_status", {busy, running, snap_valid, tick_count}, 32'h0);
    reset_n = 1'b1;
    @(negedge clk);
    check("idle_snap_value", snap_value, 32'h0);

    // program period 9 from IDLE
    start_timer(32'h0000_0009, 1'b0);

    // three timeouts, one status clear each
    wait_clr(3, "clr3_wait");
    @(negedge clk);
    check("tick_after_3", 32'(tick_count), 32'(exp_tick));

    // wrap: preload 0xFFFF, next timeout wraps to 0
    force dut.tick_count_q = 16'hFFFF;
    exp_tick = 16'hFFFF;
    @(negedge clk);
    release dut.tick_count_q;
    wait_clr(4, "clr4_wait");
    @(negedge clk);
    check("tick_wrap", 32'(tick_count), 32'(exp_tick));

    // snapshot while running, model returns 0x1234 / 0x0000
    push_snap(16'h1234, 16'h0000);
    snap_req = 1'b1;
    @(posedge clk); #1;
    snap_req = 1'b0;
    k = 0;
    while (!snap_valid && k < 20) begin @(negedge clk); k++; end
    check("snap_latency", k, 6);
    @(negedge clk);
    check("snap_valid_pulse", 32'(snap_valid), 32'd0);

    // stop and timeout in the same RUN cycle: stop wins, no status clear
    k = 0;
    while (!(t_run && t_cnt == 32'd0) && k < 40) begin @(negedge clk); k++; end
    check("cnt_zero_wait", 32'(t_cnt), 32'd0);
    clr_track = 1'b0;
    @(posedge clk); #1;
    cfg_stop = 1'b1;
    exp_q.push_back({1'b1, 3'd1, 16'h0008});
    check("irq_with_stop", 32'(irq_in), 32'd1);
    @(posedge clk); #1;
    cfg_stop = 1'b0;
    @(negedge clk);
    check("stop_first", {m_chipselect, m_write_n, m_address}, {1'b1, 1'b0, 3'd1});
    @(negedge clk);
    check("stop_running", 32'(running), 32'd0);
    repeat (3) @(negedge clk);
    check("stop_tick", 32'(tick_count), 32'(exp_tick));
    check("stop_busy", 32'(busy), 32'd0);

    // snapshot from IDLE, reset hits during RD_SL_W
    lo = 16'($urandom_range(0, 65535));
    hi = 16'($urandom_range(0, 65535));
    push_snap(lo, hi);
    @(posedge clk); #1;
    snap_req = 1'b1;
    @(posedge clk); #1;
    snap_req = 1'b0;
    k = 0;
    while (!(m_chipselect && m_write_n && m_address == 3'd4) && k < 20) begin
      @(negedge clk); k++;
    end
    check("rd_sl_seen", 32'(m_address), 32'd4);
    @(posedge clk); #2;
    reset_n = 1'b0;
    #1;
    check("arst_bus", {m_chipselect, m_write_n, m_address, m_writedata}, {1'b0, 1'b1, 3'd0, 16'h0});
    check("arst_status", {busy, running, snap_valid, tick_count}, 32'h0);
    check("arst_snap_value", snap_value, 32'h0);
    exp_q.delete();
    snap_exp_q.delete();
    exp_tick = 16'h0;
    clr_track = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // long period, then reprogram from RUN with a short one
    start_timer({16'($urandom_range(1, 65535)), 16'($urandom_range(0, 65535))}, 1'b0);
    start_timer(32'($urandom_range(10, 20)), 1'b1);
    base = n_clr_seen;
    wait_clr(base + 2, "clr_reprog_wait");
    @(negedge clk);
    check("tick_reprog", 32'(tick_count), 32'(exp_tick));

    // stop arrives mid-snapshot: held pending and serviced once back in RUN
    clr_track = 1'b0;
    lo = 16'($urandom_range(0, 65535));
    hi = 16'($urandom_range(0, 65535));
    push_snap(lo, hi);
    snap_req = 1'b1;
    @(posedge clk); #1;
    snap_req = 1'b0;
    cfg_stop = 1'b1;
    exp_q.push_back({1'b1, 3'd1, 16'h0008});
    @(posedge clk); #1;
    cfg_stop = 1'b0;
    k = 0;
    while (running && k < 30) begin @(negedge clk); k++; end
    check("pend_stop_running", 32'(running), 32'd0);
    repeat (3) @(negedge clk);
    check("final_busy", 32'(busy), 32'd0);
    check("final_tick", 32'(tick_count), 32'(exp_tick));
    check("exp_q_drained", 32'(exp_q.size()), 32'd0);
    check("snap_q_drained", 32'(snap_exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
